audio_sdm_out: RTL

//  APB-programmed stereo audio source: buffers 16-bit stereo samples in a small FIFO, paces them at DIV+1
//  clk cycles/sample, drives each channel through a 1st-order sigma-delta modulator -> 1-bit audio_l/audio_r.

---
 rtl/audio_sdm_pkg.sv | 31 +++
 rtl/audio_sdm_chan.sv | 31 +++
 rtl/audio_sdm_out.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/audio_sdm_pkg.sv
// Shared definitions for the stereo sigma-delta audio source: register map, CSR bit positions,
// reset values and the signed-to-offset-binary helper used by the modulators.
package audio_sdm_pkg;

  localparam logic [1:0] AddrCsr  = 2'd0;
  localparam logic [1:0] AddrDiv  = 2'd1;
  localparam logic [1:0] AddrFifo = 2'd2;
  localparam logic [1:0] AddrRsvd = 2'd3;

  localparam int unsigned CsrEnBit     = 0;
  localparam int unsigned CsrUnfBit    = 1;
  localparam int unsigned CsrOvfBit    = 2;
  localparam int unsigned CsrFlushBit  = 3;
  localparam int unsigned CsrFullBit   = 4;
  localparam int unsigned CsrEmptyBit  = 5;
  localparam int unsigned CsrLevelLsb  = 8;
  localparam int unsigned CsrThreshLsb = 16;

  localparam int unsigned DivReset = 1023;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] l;
  } stereo_t;

  // Flipping the sign bit maps two's complement onto 0..65535 with 0x8000 as silence.
  function automatic logic [15:0] to_offset(input logic [15:0] s);
    return {~s[15], s[14:0]};
  endfunction

endpackage

// File: rtl/audio_sdm_chan.sv
// One first-order sigma-delta channel: accumulates the offset-binary sample each enabled cycle
// and emits the accumulator carry as the 1-bit output.
module audio_sdm_chan
  import audio_sdm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [15:0] i_sample,
  output logic        o_out
);

  logic [15:0] r_acc;
  logic        r_out;
  logic [16:0] w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, to_offset(i_sample)};

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_acc <= '0;
      r_out <= 1'b0;
    end else begin
      r_acc <= w_sum[15:0];
      r_out <= w_sum[16];
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/audio_sdm_out.sv
// APB-programmed stereo audio source: sample FIFO, period divider and two sigma-delta channels.
// Optional macro AUDIO_SDM_IRQ_EN adds the IRQ_THRESH field and the FIFO-low irq output.
module audio_sdm_out
  import audio_sdm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        apbs_psel,
  input  logic        apbs_penable,
  input  logic        apbs_pwrite,
  input  logic [15:0] apbs_paddr,
  input  logic [31:0] apbs_pwdata,
  output logic [31:0] apbs_prdata,
  output logic        apbs_pready,
  output logic        apbs_pslverr,
  output logic        audio_l,
  output logic        audio_r
`ifdef AUDIO_SDM_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic             r_en, r_unf, r_ovf;
  logic [W_DIV-1:0] r_div, r_cnt;
  logic [31:0]      r_cur;
  logic [31:0]      r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;

  logic [1:0]    w_addr;
  logic          w_wr, w_csr_wr, w_div_wr, w_push_req;
  logic          w_tick, w_flush, w_pop, w_push, w_unf_set, w_ovf_set;
  logic          w_empty, w_full;
  logic [PW-1:0] w_level;
  logic [31:0]   w_csr;
  logic          w_unused;
  stereo_t       w_cur;

  assign w_addr     = apbs_paddr[3:2];
  assign w_wr       = apbs_psel & apbs_penable & apbs_pwrite;
  assign w_csr_wr   = w_wr & (w_addr == AddrCsr);
  assign w_div_wr   = w_wr & (w_addr == AddrDiv);
  assign w_push_req = w_wr & (w_addr == AddrFifo);
  assign w_unused   = ^{apbs_paddr[15:4], apbs_paddr[1:0]};

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_level = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_tick    = r_en && (r_cnt == '0);
  assign w_flush   = w_csr_wr & apbs_pwdata[CsrFlushBit];
  assign w_pop     = w_tick & ~w_empty & ~w_flush;
  assign w_push    = w_push_req & ~w_flush & (~w_full | w_pop);
  assign w_unf_set = w_tick & w_empty;
  assign w_ovf_set = w_push_req & ~w_flush & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_unf  <= 1'b0;
      r_ovf  <= 1'b0;
      r_div  <= W_DIV'(DivReset);
      r_cnt  <= W_DIV'(DivReset);
      r_cur  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_csr_wr) r_en <= apbs_pwdata[CsrEnBit];
      // Set events win over a same-cycle write-one-to-clear.
      r_unf <= (r_unf & ~(w_csr_wr & apbs_pwdata[CsrUnfBit])) | w_unf_set;
      r_ovf <= (r_ovf & ~(w_csr_wr & apbs_pwdata[CsrOvfBit])) | w_ovf_set;
      if (w_div_wr) r_div <= apbs_pwdata[W_DIV-1:0];
      if (!r_en || r_cnt == '0) r_cnt <= r_div;
      else                      r_cnt <= r_cnt - W_DIV'(1);
      if (w_flush) begin
        r_rptr <= r_wptr;
      end else begin
        if (w_pop) begin
          r_cur  <= r_mem[r_rptr[AW-1:0]];
          r_rptr <= r_rptr + PW'(1);
        end
        if (w_push) begin
          r_mem[r_wptr[AW-1:0]] <= apbs_pwdata;
          r_wptr                <= r_wptr + PW'(1);
        end
      end
    end
  end

`ifdef AUDIO_SDM_IRQ_EN
  logic [3:0] r_thresh;
  logic       r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_thresh <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_csr_wr) r_thresh <= apbs_pwdata[CsrThreshLsb +: 4];
      r_irq <= r_en & (4'(w_level) <= r_thresh);
    end
  end

  assign irq = r_irq;
`endif

  always_comb begin
    w_csr                     = '0;
    w_csr[CsrEnBit]           = r_en;
    w_csr[CsrUnfBit]          = r_unf;
    w_csr[CsrOvfBit]          = r_ovf;
    w_csr[CsrFullBit]         = w_full;
    w_csr[CsrEmptyBit]        = w_empty;
    w_csr[CsrLevelLsb +: 4]   = 4'(w_level);
`ifdef AUDIO_SDM_IRQ_EN
    w_csr[CsrThreshLsb +: 4]  = r_thresh;
`endif
  end

  always_comb begin
    apbs_prdata = '0;
    if (apbs_psel) begin
      case (w_addr)
        AddrCsr: apbs_prdata = w_csr;
        AddrDiv: apbs_prdata = 32'(r_div);
        default: apbs_prdata = '0;
      endcase
    end
  end

  assign apbs_pready  = 1'b1;
  assign apbs_pslverr = 1'b0;

  assign w_cur = r_cur;

  audio_sdm_chan u_chan_l (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_en),
    .i_sample (w_cur.l),
    .o_out    (audio_l)
  );

  audio_sdm_chan u_chan_r (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_en),
    .i_sample (w_cur.r),
    .o_out    (audio_r)
  );

endmodule
